debounce_edge: RTL

Debounce and edge-detect stage sitting directly downstream of the input synchronizer. It consumes the synchronizer's already-metastability-hardened `out` signal and accepts a new level only after a programmable number of consecutive identical samples. It emits a clean registered level, single-cycle rise/fall pulses and an optional wrapping rising-edge event count for control logic further down the design.

---
 rtl/debounce_edge.sv | 130 +++++++++++++
 1 files changed

// File: rtl/debounce_edge.sv
// Debounce plus edge detect: accepts a new level after STABLE_CYCLES identical samples.
// Emits registered level/rise/fall; optional rising-edge counter built under DEBOUNCE_EVT_CNT_EN.
module debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4,
    parameter int EVT_W         = 8
) (
    input  logic             clk,
    input  logic             g_reset,
    input  logic             sync_in,
    input  logic             evt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_count
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             rise_r;
    logic             fall_r;
    logic             accept_rise_s;

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

    // Same condition the FSM uses to fire rise, shared with the event counter.
    assign accept_rise_s = (state_r == WAIT_HI) && sync_in && (cnt_r == CNT_LAST);

    // Debounce FSM with stability counter and registered level/pulse outputs.
    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            state_r <= IDLE_LO;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                IDLE_LO: begin
                    if (sync_in) begin
                        state_r <= WAIT_HI;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                WAIT_HI: begin
                    if (!sync_in) begin
                        state_r <= IDLE_LO;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE_HI;
                        level_r <= 1'b1;
                        rise_r  <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                IDLE_HI: begin
                    if (!sync_in) begin
                        state_r <= WAIT_LO;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                WAIT_LO: begin
                    if (sync_in) begin
                        state_r <= IDLE_HI;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE_LO;
                        level_r <= 1'b0;
                        fall_r  <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE_LO;
                    cnt_r   <= CNT_ZERO;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EVT_CNT_EN
    logic [EVT_W-1:0] evt_r;

    assign evt_count = evt_r;

    // Wrapping rise counter; a clear on a rise edge keeps that rise.
    always_ff @(posedge clk or negedge g_reset) begin
        if (!g_reset) begin
            evt_r <= {EVT_W{1'b0}};
        end else if (evt_clr) begin
            evt_r <= accept_rise_s ? EVT_W'(1) : {EVT_W{1'b0}};
        end else if (accept_rise_s) begin
            evt_r <= evt_r + EVT_W'(1);
        end else begin
            evt_r <= evt_r;
        end
    end
`else
    logic unused_evt_s;

    assign unused_evt_s = evt_clr ^ accept_rise_s;
    assign evt_count    = {EVT_W{1'b0}};
`endif

endmodule
